// File: rtl/sdp_ram_be.sv
// sdp_ram_be -- simple dual-port RAM with per-byte write enables, an
// independent read port of configurable latency (1 or 2), and a built-in
// clear sequencer that zeroes the array one word per cycle after reset or
// on request.
//
// Optional feature macro: WR_FORWARD_EN
//   defined   -> a same-cycle, same-address read returns the merged new word
//                (write-first)
//   undefined -> the same read returns the old word (read-first)
//
// Ports:
//   clk       in   clock, all state changes on the rising edge
//   reset     in   asynchronous, active-high reset
//   clear     in   single-cycle request to zero the array (ignored while busy)
//   busy      out  high while the clear sequencer owns the array
//   wr_en     in   write request
//   wr_addr   in   write address
//   wr_be     in   byte enables, bit i covers wr_data[i*BYTE_WIDTH +: BYTE_WIDTH]
//   wr_data   in   write data
//   rd_en     in   read request
//   rd_addr   in   read address
//   rd_data   out  read data, holds its last value when no read completes
//   rd_valid  out  one-cycle pulse when rd_data carries a new result
//
// Handshake: there is no back-pressure. A port request is accepted on any
// rising edge where wr_en/rd_en is high and busy is low; requests made while
// busy is high are dropped. Every accepted read produces exactly one rd_valid
// pulse RD_LATENCY cycles later, in request order.
module sdp_ram_be #(
    parameter int DATA_WIDTH = 32,
    parameter int BYTE_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int RD_LATENCY = 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             clear,
    output logic                             busy,
    input  logic                             wr_en,
    input  logic [ADDR_WIDTH-1:0]            wr_addr,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] wr_be,
    input  logic [DATA_WIDTH-1:0]            wr_data,
    input  logic                             rd_en,
    input  logic [ADDR_WIDTH-1:0]            rd_addr,
    output logic [DATA_WIDTH-1:0]            rd_data,
    output logic                             rd_valid
);

    localparam int NUM_BYTES = DATA_WIDTH / BYTE_WIDTH;
    // One extra bit so DEPTH itself is representable when DEPTH is a power of two.
    localparam logic [ADDR_WIDTH:0]   DEPTH_L   = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   clr_cnt_q, clr_cnt_d;
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

    logic                    wr_in_range;
    logic                    rd_in_range;
    logic                    wr_ok;
    logic                    rd_ok;
    logic [DATA_WIDTH-1:0]   rd_word;

    logic                    rd_v1_q, rd_v1_d;
    logic [DATA_WIDTH-1:0]   rd_d1_q, rd_d1_d;

    // ------------------------------------------------------------------
    // Clear sequencer
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            CLEAR: begin
                // clear requests are ignored here: the sweep never restarts
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == LAST_ADDR) begin
                    state_d   = READY;
                    clr_cnt_d = '0;
                end
            end
            READY: begin
                if (clear) begin
                    state_d   = CLEAR;
                    clr_cnt_d = '0;
                end
            end
            default: begin
                state_d   = CLEAR;
                clr_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= CLEAR;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    assign busy = (state_q == CLEAR);

    // ------------------------------------------------------------------
    // Port qualification
    // ------------------------------------------------------------------
    assign wr_in_range = ({1'b0, wr_addr} < DEPTH_L);
    assign rd_in_range = ({1'b0, rd_addr} < DEPTH_L);
    assign wr_ok       = (state_q == READY) && wr_en && wr_in_range;
    assign rd_ok       = (state_q == READY) && rd_en;

    // ------------------------------------------------------------------
    // Array: the sweep has priority, but it only runs while the ports are
    // locked out, so the two write sources never compete in practice.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (state_q == CLEAR) begin
            mem_q[clr_cnt_q] <= '0;
        end else if (wr_ok) begin
            for (int b = 0; b < NUM_BYTES; b++) begin
                if (wr_be[b]) begin
                    mem_q[wr_addr][b*BYTE_WIDTH +: BYTE_WIDTH] <= wr_data[b*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read word selection (out-of-range reads return zero)
    // ------------------------------------------------------------------
    always_comb begin
        rd_word = '0;
        if (rd_in_range) begin
            rd_word = mem_q[rd_addr];
        end
`ifdef WR_FORWARD_EN
        // wr_ok already implies an in-range address, so equality implies the
        // read is in range too.
        if (wr_ok && (wr_addr == rd_addr)) begin
            for (int b = 0; b < NUM_BYTES; b++) begin
                if (wr_be[b]) begin
                    rd_word[b*BYTE_WIDTH +: BYTE_WIDTH] = wr_data[b*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
`endif
    end

    // ------------------------------------------------------------------
    // Read pipeline stage 1; data only moves when a read completes so the
    // output holds between results. Not flushed by clear: in-flight reads
    // complete with the data they sampled.
    // ------------------------------------------------------------------
    always_comb begin
        rd_v1_d = rd_ok;
        rd_d1_d = rd_ok ? rd_word : rd_d1_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_v1_q <= 1'b0;
            rd_d1_q <= '0;
        end else begin
            rd_v1_q <= rd_v1_d;
            rd_d1_q <= rd_d1_d;
        end
    end

    generate
        if (RD_LATENCY == 2) begin : g_lat2
            logic                  rd_v2_q, rd_v2_d;
            logic [DATA_WIDTH-1:0] rd_d2_q, rd_d2_d;

            always_comb begin
                rd_v2_d = rd_v1_q;
                rd_d2_d = rd_v1_q ? rd_d1_q : rd_d2_q;
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    rd_v2_q <= 1'b0;
                    rd_d2_q <= '0;
                end else begin
                    rd_v2_q <= rd_v2_d;
                    rd_d2_q <= rd_d2_d;
                end
            end

            assign rd_valid = rd_v2_q;
            assign rd_data  = rd_d2_q;
        end else begin : g_lat1
            assign rd_valid = rd_v1_q;
            assign rd_data  = rd_d1_q;
        end
    endgenerate

endmodule

// File: tb/tb_sdp_ram_be.sv
// Testbench for sdp_ram_be. Two instances share one stimulus stream:
//   u_a : DEPTH=16, RD_LATENCY=1
//   u_b : DEPTH=12, RD_LATENCY=2 (addresses 12..15 are out of range)
// A behavioural model (plain word arrays, a count of remaining sweep words and
// a queue of reads tagged with the cycle they are due) predicts busy, rd_valid
// and rd_data for both after every rising edge.
module tb_sdp_ram_be;

    logic        clk = 1'b0;
    logic        reset;
    logic        clear;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [3:0]  wr_be;
    logic [31:0] wr_data;
    logic        rd_en;
    logic [3:0]  rd_addr;
    logic        busy_a, busy_b;
    logic        rd_valid_a, rd_valid_b;
    logic [31:0] rd_data_a, rd_data_b;

    always #5 clk = ~clk;

    sdp_ram_be #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .DEPTH(16), .RD_LATENCY(1)) u_a (
        .clk(clk), .reset(reset), .clear(clear), .busy(busy_a),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_valid(rd_valid_a)
    );

    sdp_ram_be #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .DEPTH(12), .RD_LATENCY(2)) u_b (
        .clk(clk), .reset(reset), .clear(clear), .busy(busy_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_valid(rd_valid_b)
    );

    // ---------------- reference model ----------------
    typedef struct {
        int          dut;
        int          due;
        logic [31:0] data;
    } rd_t;

    int          depth [2] = '{16, 12};
    int          lat   [2] = '{1, 2};
    logic [31:0] mem_m [2][16];
    int          rem   [2];       // words left to sweep; busy while nonzero
    logic [31:0] last_d [2];
    rd_t         exp_q [$];
    int          cyc    = 0;
    int          checks = 0;
    int          errors = 0;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[b*8 +: 8] = data[b*8 +: 8];
        end
        return r;
    endfunction

    task automatic chk(input string tag, input int dut, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s dut=%0d cycle=%0d observed=%h expected=%h", tag, dut, cyc, obs, exp);
        end
    endtask

    // Apply the effect of the coming rising edge to the model.
    task automatic model_edge();
        logic [31:0] v;
        for (int i = 0; i < 2; i++) begin
            if (rem[i] == 0) begin
                if (rd_en) begin
                    v = (int'(rd_addr) < depth[i]) ? mem_m[i][rd_addr] : 32'h0;
`ifdef WR_FORWARD_EN
                    if (wr_en && (wr_addr == rd_addr) && (int'(wr_addr) < depth[i]))
                        v = merge(v, wr_data, wr_be);
`endif
                    exp_q.push_back('{i, cyc + 1 + lat[i] - 1, v});
                end
                if (wr_en && (int'(wr_addr) < depth[i]))
                    mem_m[i][wr_addr] = merge(mem_m[i][wr_addr], wr_data, wr_be);
                if (clear) rem[i] = depth[i];
            end else begin
                mem_m[i][depth[i] - rem[i]] = 32'h0;
                rem[i]--;
            end
        end
    endtask

    task automatic check_outputs();
        logic        ev;
        logic [31:0] ed;
        for (int i = 0; i < 2; i++) begin
            ev = 1'b0;
            ed = last_d[i];
            for (int k = 0; k < exp_q.size(); k++) begin
                if (exp_q[k].dut == i && exp_q[k].due == cyc) begin
                    ev = 1'b1;
                    ed = exp_q[k].data;
                    exp_q.delete(k);
                    break;
                end
            end
            last_d[i] = ed;
            chk("busy",     i, (i == 0) ? {31'h0, busy_a}     : {31'h0, busy_b},     {31'h0, rem[i] != 0});
            chk("rd_valid", i, (i == 0) ? {31'h0, rd_valid_a} : {31'h0, rd_valid_b}, {31'h0, ev});
            chk("rd_data",  i, (i == 0) ? rd_data_a : rd_data_b, ed);
        end
    endtask

    // One clock: model the edge, take it, check #1 later, return inputs to idle.
    task automatic step();
        if (!reset) model_edge();
        @(posedge clk);
        cyc++;
        #1;
        check_outputs();
        clear = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            rem[i]    = depth[i];
            last_d[i] = 32'h0;
        end
        exp_q.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        model_reset();
        check_outputs();
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
        wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
    endtask

    task automatic read(input logic [3:0] a);
        rd_en = 1'b1; rd_addr = a;
    endtask

    task automatic read_all();
        for (int a = 0; a < 16; a++) begin
            read(4'(a));
            step();
        end
        repeat (3) step();
    endtask

    task automatic rand_inputs(input int clear_odds);
        write(4'($urandom_range(0, 15)), $urandom, 4'($urandom_range(0, 15)));
        wr_en   = 1'($urandom_range(0, 1));
        read(4'($urandom_range(0, 15)));
        rd_en   = 1'($urandom_range(0, 1));
        clear   = ($urandom_range(1, clear_odds) == 1);
    endtask

    initial begin
        reset = 1'b1; clear = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_be = '0;
        wr_data = '0; rd_en = 1'b0; rd_addr = '0;
        for (int i = 0; i < 2; i++)
            for (int a = 0; a < 16; a++) mem_m[i][a] = 32'h0;
        #1;
        model_reset();
        check_outputs();
        step();
        step();
        reset = 1'b0;

        // initial sweep, then read every address back to back
        repeat (17) step();
        read_all();

        // byte-enable merge on address 3
        write(4'd3, 32'hDEADBEEF, 4'b1111); step();
        write(4'd3, 32'h11223344, 4'b0101); step();
        read(4'd3); step();
        write(4'd3, 32'hFFFFFFFF, 4'b0000); step();
        read(4'd3); step();
        repeat (3) step();

        // same-cycle read and write of address 5
        write(4'd5, 32'hAAAAAAAA, 4'b1111); step();
        write(4'd5, 32'h55555555, 4'b1111); read(4'd5); step();
        read(4'd5); step();
        repeat (3) step();

        // address 13: stored by u_a, dropped and read as zero by u_b
        write(4'd13, 32'h13131313, 4'b1111); step();
        read(4'd13); step();
        repeat (3) step();

        // fill, then clear with reads in flight and port traffic while busy
        for (int a = 0; a < 16; a++) begin
            write(4'(a), $urandom, 4'b1111);
            step();
        end
        read(4'd0); step();
        read(4'd1); clear = 1'b1; step();
        for (int k = 0; k < 11; k++) begin
            rand_inputs(3);
            step();
        end
        repeat (6) step();
        read_all();

        // reset in the middle of a sweep
        clear = 1'b1; step();
        repeat (5) step();
        do_reset();
        repeat (17) step();
        read_all();

        // random traffic with occasional clears
        for (int k = 0; k < 400; k++) begin
            rand_inputs(60);
            step();
        end
        repeat (20) step();
        read_all();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
